tile_writer: RTL and testbench

Packs a row-major stream of PIX_BITS feature-map pixels from the CNN output into WORD_BITS-wide BRAM words and writes them through BRAM port A. It is the write-side counterpart of tile_reader: its address map and in-word pixel layout match what tile_reader expects on port B. One instance serves one tile region of the display.

---
 rtl/tile_pkg.sv | 28 ++
 rtl/pixel_packer.sv | 84 ++++++++
 rtl/tile_writer.sv | 173 +++++++++++++++++
 tb/tb_tile_writer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared tile geometry, tile_writer state encoding and layout helpers used by
// tile_writer, tile_reader and the top-level region decode.
package tile_pkg;

    localparam int              TILE_ADDR_BITS = 12;
    localparam logic [11:0]     TILE_BASE_ADDR = 12'h000;
    localparam int              TILE_W_DEF     = 24;
    localparam int              TILE_H_DEF     = 24;
    localparam int              TILE_WORD_BITS = 256;
    localparam int              TILE_PIX_BITS  = 8;

    localparam logic [1:0]      ST_IDLE   = 2'd0;
    localparam logic [1:0]      ST_ACTIVE = 2'd1;
    localparam logic [1:0]      ST_DRAIN  = 2'd2;

    // Every row starts on a fresh word, so a row takes ceil(tile_w / pixels-per-word) words.
    function automatic int words_per_row(input int tile_w, input int pix_bits, input int word_bits);
        int ppw;
        ppw = word_bits / pix_bits;
        return (tile_w + ppw - 32'sd1) / ppw;
    endfunction

    // Counter width that stays legal for a count range of one.
    function automatic int cnt_bits(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/pixel_packer.sv
// Accumulates pixels into a word, slot 0 in the LSBs, and hands each closed
// word to a separate output register so packing never stalls.
module pixel_packer
    import tile_pkg::*;
#(
    parameter int WORD_BITS = TILE_WORD_BITS,
    parameter int PIX_BITS  = TILE_PIX_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 accept,
    input  logic [PIX_BITS-1:0]  data,
    input  logic                 row_end,
    output logic                 closing,
    output logic [WORD_BITS-1:0] word,
    output logic                 word_we
);

    localparam int PPW    = WORD_BITS / PIX_BITS;
    localparam int SLOT_W = cnt_bits(PPW);

    logic [WORD_BITS-1:0] acc_r;
    logic [WORD_BITS-1:0] merged_s;
    logic [SLOT_W-1:0]    slot_r;
    logic                 close_s;
    logic [WORD_BITS-1:0] word_r;
    logic                 word_we_r;

    // Current accumulator with the incoming pixel dropped into its slot.
    always_comb begin
        merged_s = acc_r;
        merged_s[int'(slot_r) * PIX_BITS +: PIX_BITS] = data;
    end

    // A word closes when its last slot fills or the row ends early.
    always_comb begin
        if (accept && ((slot_r == SLOT_W'(PPW - 1)) || row_end)) begin
            close_s = 1'b1;
        end else begin
            close_s = 1'b0;
        end
    end

    // Accumulator and slot counter; both restart on every closed word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= {WORD_BITS{1'b0}};
            slot_r <= {SLOT_W{1'b0}};
        end else if (clear) begin
            acc_r  <= {WORD_BITS{1'b0}};
            slot_r <= {SLOT_W{1'b0}};
        end else if (close_s) begin
            acc_r  <= {WORD_BITS{1'b0}};
            slot_r <= {SLOT_W{1'b0}};
        end else if (accept) begin
            acc_r  <= merged_s;
            slot_r <= slot_r + SLOT_W'(1);
        end else begin
            acc_r  <= acc_r;
            slot_r <= slot_r;
        end
    end

    // Output word register: written one cycle after its closing pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r    <= {WORD_BITS{1'b0}};
            word_we_r <= 1'b0;
        end else begin
            word_we_r <= close_s;
            if (close_s) begin
                word_r <= merged_s;
            end else begin
                word_r <= word_r;
            end
        end
    end

    assign closing = close_s;
    assign word    = word_r;
    assign word_we = word_we_r;

endmodule

// File: rtl/tile_writer.sv
// Packs a row-major pixel stream into BRAM words laid out the way tile_reader
// expects: one row per run of words, address = base + row*wpr + word_in_row.
module tile_writer
    import tile_pkg::*;
#(
    parameter int                   ADDR_BITS = TILE_ADDR_BITS,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR = ADDR_BITS'(TILE_BASE_ADDR),
    parameter int                   TILE_W    = TILE_W_DEF,
    parameter int                   TILE_H    = TILE_H_DEF,
    parameter int                   WORD_BITS = TILE_WORD_BITS,
    parameter int                   PIX_BITS  = TILE_PIX_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [PIX_BITS-1:0]  s_data,
    input  logic                 s_last,
    output logic                 bram_we,
    output logic [ADDR_BITS-1:0] bram_addr,
    output logic [WORD_BITS-1:0] bram_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int WPR   = words_per_row(TILE_W, PIX_BITS, WORD_BITS);
    localparam int COL_W = cnt_bits(TILE_W);
    localparam int ROW_W = cnt_bits(TILE_H);
    localparam int WIR_W = cnt_bits(WPR);

    logic [1:0]           state_r;
    logic [1:0]           state_nxt_s;
    logic [COL_W-1:0]     col_r;
    logic [ROW_W-1:0]     row_r;
    logic [WIR_W-1:0]     wir_r;
    logic [ADDR_BITS-1:0] bram_addr_r;
    logic [ADDR_BITS-1:0] word_addr_s;
    logic                 ready_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 err_r;
    logic                 accept_s;
    logic                 start_ok_s;
    logic                 col_last_s;
    logic                 row_last_s;
    logic                 final_s;
    logic                 closing_s;

    assign accept_s    = s_valid && ready_r;
    assign start_ok_s  = start && (state_r == ST_IDLE);
    assign col_last_s  = (col_r == COL_W'(TILE_W - 1));
    assign row_last_s  = (row_r == ROW_W'(TILE_H - 1));
    assign final_s     = accept_s && col_last_s && row_last_s;
    assign word_addr_s = BASE_ADDR + (ADDR_BITS'(row_r) * ADDR_BITS'(WPR)) + ADDR_BITS'(wir_r);

    pixel_packer #(
        .WORD_BITS (WORD_BITS),
        .PIX_BITS  (PIX_BITS)
    ) u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_ok_s),
        .accept  (accept_s),
        .data    (s_data),
        .row_end (col_last_s),
        .closing (closing_s),
        .word    (bram_wdata),
        .word_we (bram_we)
    );

    // Next-state decode; start outside IDLE falls through unnoticed.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_ACTIVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (final_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            ST_DRAIN: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State plus status flags, all registered from the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == ST_ACTIVE);
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= final_s;
        end
    end

    // Raster position of the next pixel; advances only on accepted pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (start_ok_s) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (accept_s) begin
            if (col_last_s) begin
                col_r <= {COL_W{1'b0}};
                row_r <= row_last_s ? {ROW_W{1'b0}} : (row_r + ROW_W'(1));
            end else begin
                col_r <= col_r + COL_W'(1);
                row_r <= row_r;
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // Word-in-row index and the address latched alongside each closed word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wir_r       <= {WIR_W{1'b0}};
            bram_addr_r <= {ADDR_BITS{1'b0}};
        end else if (start_ok_s) begin
            wir_r       <= {WIR_W{1'b0}};
            bram_addr_r <= bram_addr_r;
        end else if (closing_s) begin
            wir_r       <= col_last_s ? {WIR_W{1'b0}} : (wir_r + WIR_W'(1));
            bram_addr_r <= word_addr_s;
        end else begin
            wir_r       <= wir_r;
            bram_addr_r <= bram_addr_r;
        end
    end

    // Sticky framing error: s_last must mark exactly the final pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (start_ok_s) begin
            err_r <= 1'b0;
        end else if (accept_s && (s_last != (col_last_s && row_last_s))) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign s_ready   = ready_r;
    assign bram_addr = bram_addr_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_tile_writer.sv
// Randomized bench for tile_writer: a picture-level model predicts every BRAM
// word, its address and the cycle it must be written.
module tb_tile_writer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         s_valid = 1'b0;
    logic [7:0]   s_data = 8'h00;
    logic         s_last = 1'b0;
    int           sel = 0;

    logic         a_ready, a_we, a_busy, a_done, a_err;
    logic [11:0]  a_addr;
    logic [255:0] a_wdata;
    logic         b_ready, b_we, b_busy, b_done, b_err;
    logic [11:0]  b_addr;
    logic [255:0] b_wdata;

    logic         cur_ready, cur_we, cur_busy, cur_done, cur_err;
    logic [11:0]  cur_addr;
    logic [255:0] cur_wdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wr = 0;
    int done_cnt = 0;
    int wr_base, done_base, nw, tw, th, base, wpr;

    logic [7:0]   pix [1024];
    logic [255:0] exp_word [64];
    int           exp_addr [64];
    int           close_idx [64];
    int           acc_q [$];

    always #5 clk = ~clk;

    tile_writer dut_a (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 0), .s_valid(s_valid && sel == 0),
        .s_ready(a_ready), .s_data(s_data), .s_last(s_last), .bram_we(a_we), .bram_addr(a_addr),
        .bram_wdata(a_wdata), .busy(a_busy), .done(a_done), .err(a_err)
    );

    tile_writer #(.BASE_ADDR(12'h010), .TILE_W(40), .TILE_H(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 1), .s_valid(s_valid && sel == 1),
        .s_ready(b_ready), .s_data(s_data), .s_last(s_last), .bram_we(b_we), .bram_addr(b_addr),
        .bram_wdata(b_wdata), .busy(b_busy), .done(b_done), .err(b_err)
    );

    always_comb begin
        if (sel == 1) begin
            {cur_ready, cur_we, cur_busy, cur_done, cur_err} = {b_ready, b_we, b_busy, b_done, b_err};
            cur_addr = b_addr;
            cur_wdata = b_wdata;
        end else begin
            {cur_ready, cur_we, cur_busy, cur_done, cur_err} = {a_ready, a_we, a_busy, a_done, a_err};
            cur_addr = a_addr;
            cur_wdata = a_wdata;
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every strobe is matched against the next predicted word.
    always @(negedge clk) begin
        if (rst_n && cur_we) begin
            if (wr - wr_base < nw) begin
                check("we_addr", 256'(cur_addr), 256'(exp_addr[wr - wr_base]));
                check("we_data", cur_wdata, exp_word[wr - wr_base]);
                if (acc_q.size() > 0) check("we_latency", 256'(cyc), 256'(acc_q.pop_front()));
                else check("we_without_close", 256'(cyc), 256'(0));
            end else begin
                check("extra_we", 256'(cur_we), 256'(0));
            end
            wr <= wr + 1;
        end
        if (rst_n && cur_done) begin
            check("done_with_we", 256'(cur_we), 256'(1));
            done_cnt <= done_cnt + 1;
        end
    end

    // Picture-level model: pixel values and the word list they must produce.
    task automatic build_model(input int pat);
        int ppw, c, lc;
        tw = (sel == 1) ? 40 : 24;
        th = (sel == 1) ? 2 : 24;
        base = (sel == 1) ? 16 : 0;
        ppw = 32;
        wpr = (tw + ppw - 1) / ppw;
        for (int i = 0; i < tw * th; i++) pix[i] = (pat == 0) ? 8'(i) : 8'($urandom_range(255));
        nw = 0;
        for (int r = 0; r < th; r++) begin
            for (int w = 0; w < wpr; w++) begin
                exp_word[nw] = '0;
                for (int k = 0; k < ppw; k++) begin
                    c = w * ppw + k;
                    if (c < tw) exp_word[nw][k*8 +: 8] = pix[r * tw + c];
                end
                exp_addr[nw] = base + r * wpr + w;
                lc = (w * ppw + ppw - 1 < tw - 1) ? (w * ppw + ppw - 1) : (tw - 1);
                close_idx[nw] = r * tw + lc;
                nw++;
            end
        end
    endtask

    task automatic run_tile(input int pat, input int gap_pct, input int last_idx,
                            input int mid_start, input int abort_after);
        int n, idx, wq, stalls, budget, exp_wr;
        build_model(pat);
        n = tw * th;
        acc_q.delete();
        wr_base = wr;
        done_base = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_ready", 256'(cur_ready), 256'(1));
        check("start_busy", 256'(cur_busy), 256'(1));
        check("start_err_clear", 256'(cur_err), 256'(0));
        idx = 0; wq = 0; stalls = 0; budget = 0;
        while (idx < n && budget < 8 * n + 50) begin
            s_valid = ($urandom_range(99) >= gap_pct);
            s_data = pix[idx];
            s_last = (idx == last_idx);
            start = (idx == mid_start);
            @(negedge clk);
            if (s_valid && cur_ready) begin
                if (wq < nw && idx == close_idx[wq]) begin
                    acc_q.push_back(cyc + 1);
                    wq++;
                end
                idx++;
            end else if (s_valid) begin
                stalls++;
            end
            if (abort_after > 0 && idx == abort_after) break;
            @(posedge clk); #1;
            budget++;
        end
        s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
        if (abort_after > 0) begin
            @(posedge clk); #1;
            rst_n = 1'b0;
            #1;
            check("rst_we", 256'(cur_we), 256'(0));
            check("rst_ready", 256'(cur_ready), 256'(0));
            check("rst_busy", 256'(cur_busy), 256'(0));
            check("rst_addr", 256'(cur_addr), 256'(0));
            check("rst_wdata", cur_wdata, 256'(0));
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (4) @(negedge clk);
            check("abort_idle_busy", 256'(cur_busy), 256'(0));
            check("abort_idle_ready", 256'(cur_ready), 256'(0));
            exp_wr = 0;
            for (int i = 0; i < nw; i++) if (close_idx[i] < abort_after) exp_wr++;
            check("abort_wr_count", 256'(wr - wr_base), 256'(exp_wr));
            acc_q.delete();
            @(posedge clk); #1;
            return;
        end
        check("accept_all", 256'(idx), 256'(n));
        if (gap_pct == 0) check("no_stall", 256'(stalls), 256'(0));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cur_done) break;
        end
        check("done_seen", 256'(cur_done), 256'(1));
        check("done_busy", 256'(cur_busy), 256'(1));
        @(negedge clk);
        check("busy_fall", 256'(cur_busy), 256'(0));
        check("ready_idle", 256'(cur_ready), 256'(0));
        check("done_pulse", 256'(cur_done), 256'(0));
        check("err_final", 256'(cur_err), 256'((last_idx != n - 1) ? 1 : 0));
        check("wr_count", 256'(wr - wr_base), 256'(nw));
        check("done_count", 256'(done_cnt - done_base), 256'(1));
        check("pending_close", 256'(acc_q.size()), 256'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        nw = 0; wr_base = 0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            check("reset_ready", 256'(cur_ready), 256'(0));
            check("reset_we", 256'(cur_we), 256'(0));
            check("reset_busy", 256'(cur_busy), 256'(0));
            check("reset_done", 256'(cur_done), 256'(0));
            check("reset_err", 256'(cur_err), 256'(0));
            check("reset_addr", 256'(cur_addr), 256'(0));
            check("reset_wdata", cur_wdata, 256'(0));
        end
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_tile(0, 0, 575, -1, 0);       // defaults, continuous
        sel = 1;
        run_tile(0, 0, 79, -1, 0);        // 40x2 at 0x010
        sel = 0;
        run_tile(0, 30, 575, -1, 0);      // same picture with gaps
        run_tile(1, 50, 575, -1, 0);      // random pixels, heavy gaps
        run_tile(1, 0, 100, -1, 0);       // early s_last
        run_tile(0, 20, 575, -1, 30);     // reset after 30 pixels
        run_tile(0, 0, 575, -1, 0);       // full rewrite after reset
        run_tile(1, 10, 575, 200, 0);     // start mid-tile ignored

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule
